// File: rtl/fetch_pkg.sv
// Shared Fetch-2 types: bundle geometry, buffer entry layout and the slot-mask helper.
package fetch_pkg;
  localparam int FETCH_WIDTH = 4;
  localparam int SIZE_PC     = 32;
  localparam int INST_W      = 64;
  localparam int OFF_LSB     = 3;

  typedef struct packed {
    logic [SIZE_PC-1:0] pc;
    logic [INST_W-1:0]  inst;
    logic               pred_taken;
    logic [SIZE_PC-1:0] pred_target;
  } ibuf_entry_t;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] valid;
    logic                   taken;
    logic [1:0]             taken_slot;
  } slot_mask_t;

  // Live slots run from the PC offset up to and including the first predicted-taken hit.
  function automatic slot_mask_t slot_mask(input logic [1:0] off,
                                           input logic [FETCH_WIDTH-1:0] btb_hit,
                                           input logic [FETCH_WIDTH-1:0] prediction);
    slot_mask_t r;
    r = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (k >= int'(off) && !r.taken) begin
        r.valid[k] = 1'b1;
        if (btb_hit[k] && prediction[k]) begin
          r.taken      = 1'b1;
          r.taken_slot = 2'(k);
        end
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/fetch2_slot_compactor.sv
// Packs the masked bundle slots lowest-first and counts them; purely combinational,
// zero latency, no flow control of its own.
module fetch2_slot_compactor
  import fetch_pkg::*;
(
  input  logic [FETCH_WIDTH-1:0]        mask,
  input  ibuf_entry_t [FETCH_WIDTH-1:0] slots,
  output logic [2:0]                    n_enq,
  output ibuf_entry_t [FETCH_WIDTH-1:0] packed_ent
);
  always_comb begin
    packed_ent = '0;
    n_enq      = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (mask[k]) begin
        packed_ent[n_enq[1:0]] = slots[k];
        n_enq = n_enq + 3'd1;
      end
    end
  end
endmodule

// File: rtl/fetch2_inst_buffer.sv
// Fetch-2 instruction buffer: masks/compacts bundles into a circular queue, shows up to 4 oldest to Decode
// one cycle after acceptance; stall_o (registered count only) holds upstream when a full bundle may not fit.
module fetch2_inst_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           fs1Ready_i,
  input  logic [SIZE_PC-1:0]             pc_i,
  input  logic [FETCH_WIDTH*INST_W-1:0]  instructionBundle_i,
  input  logic [FETCH_WIDTH-1:0]         btbHit_i,
  input  logic [FETCH_WIDTH-1:0]         prediction_i,
  input  logic [FETCH_WIDTH*SIZE_PC-1:0] targetAddr_i,
  input  logic                           decodeReady_i,
  output logic                           stall_o,
  output logic [FETCH_WIDTH-1:0]         instValid_o,
  output logic [FETCH_WIDTH*SIZE_PC-1:0] instPC_o,
  output logic [FETCH_WIDTH*INST_W-1:0]  inst_o,
  output logic [FETCH_WIDTH-1:0]         predTaken_o,
  output logic [FETCH_WIDTH*SIZE_PC-1:0] predTarget_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] STALL_LVL = (PTR_W+1)'(DEPTH - FETCH_WIDTH);
  localparam logic [PTR_W:0] FW_CNT    = (PTR_W+1)'(FETCH_WIDTH);

  ibuf_entry_t mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  slot_mask_t                    mask;
  ibuf_entry_t [FETCH_WIDTH-1:0] slots, packed_ent;
  logic [2:0]                    n_enq;
  logic                          do_enq;
  logic [PTR_W:0]                enq_cnt, deq_cnt;
  logic                          unused_pc_lsbs;

  assign unused_pc_lsbs = ^pc_i[OFF_LSB-1:0];

  always_comb begin
    slots = '0;
    mask  = slot_mask(pc_i[OFF_LSB+1:OFF_LSB], btbHit_i, prediction_i);
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slots[k].pc          = {pc_i[SIZE_PC-1:OFF_LSB+2], 2'(k), {OFF_LSB{1'b0}}};
      slots[k].inst        = instructionBundle_i[k*INST_W +: INST_W];
      slots[k].pred_taken  = mask.taken && (mask.taken_slot == 2'(k));
      slots[k].pred_target = targetAddr_i[k*SIZE_PC +: SIZE_PC];
    end
  end

  fetch2_slot_compactor u_compactor (
    .mask       (mask.valid),
    .slots      (slots),
    .n_enq      (n_enq),
    .packed_ent (packed_ent)
  );

  assign stall_o = (count > STALL_LVL);
  assign do_enq  = fs1Ready_i && !stall_o && !reset && !flush_i;
  assign enq_cnt = do_enq ? (PTR_W+1)'(n_enq) : '0;
  assign deq_cnt = decodeReady_i ? ((count > FW_CNT) ? FW_CNT : count) : '0;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + deq_cnt[PTR_W-1:0];
      tail  <= tail + enq_cnt[PTR_W-1:0];
      count <= count + enq_cnt - deq_cnt;
    end
  end

  // Payload storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (3'(i) < n_enq) mem[tail + PTR_W'(i)] <= packed_ent[i];
      end
    end
  end

  always_comb begin
    instValid_o  = '0;
    instPC_o     = '0;
    inst_o       = '0;
    predTaken_o  = '0;
    predTarget_o = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      instValid_o[i]                      = ((PTR_W+1)'(i) < count);
      instPC_o[i*SIZE_PC +: SIZE_PC]      = mem[head + PTR_W'(i)].pc;
      inst_o[i*INST_W +: INST_W]          = mem[head + PTR_W'(i)].inst;
      predTaken_o[i]                      = mem[head + PTR_W'(i)].pred_taken;
      predTarget_o[i*SIZE_PC +: SIZE_PC]  = mem[head + PTR_W'(i)].pred_target;
    end
  end
endmodule

// File: tb/tb_fetch2_inst_buffer.sv
// Bench for fetch2_inst_buffer: queue-based reference of the buffer contents plus directed literal checks.
module tb_fetch2_inst_buffer;
  logic         clk = 1'b0;
  logic         reset, flush_i, fs1Ready_i, decodeReady_i;
  logic [31:0]  pc_i;
  logic [255:0] instructionBundle_i;
  logic [3:0]   btbHit_i, prediction_i;
  logic [127:0] targetAddr_i;
  logic         stall_o;
  logic [3:0]   instValid_o, predTaken_o;
  logic [127:0] instPC_o, predTarget_o;
  logic [255:0] inst_o;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] inst;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;
  exp_t mq[$];

  always #5 clk = ~clk;

  fetch2_inst_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .flush_i             (flush_i),
    .fs1Ready_i          (fs1Ready_i),
    .pc_i                (pc_i),
    .instructionBundle_i (instructionBundle_i),
    .btbHit_i            (btbHit_i),
    .prediction_i        (prediction_i),
    .targetAddr_i        (targetAddr_i),
    .decodeReady_i       (decodeReady_i),
    .stall_o             (stall_o),
    .instValid_o         (instValid_o),
    .instPC_o            (instPC_o),
    .inst_o              (inst_o),
    .predTaken_o         (predTaken_o),
    .predTarget_o        (predTarget_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] inst_of(input logic [31:0] pc, input int k);
    return {pc & ~32'h1F, 32'hC0DE0000 + 32'(k)};
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] pc, input int k);
    return (pc & ~32'h1F) + 32'h100 * 32'(k + 1);
  endfunction

  task automatic present(input logic [31:0] pc, input logic [3:0] hit, input logic [3:0] pred);
    pc_i         = pc;
    btbHit_i     = hit;
    prediction_i = pred;
    for (int k = 0; k < 4; k++) begin
      instructionBundle_i[k*64 +: 64] = inst_of(pc, k);
      targetAddr_i[k*32 +: 32]        = tgt_of(pc, k);
    end
    fs1Ready_i = 1'b1;
  endtask

  // Reference: a FIFO of expected entries, trimmed by decode and extended by accepted bundles.
  always @(posedge clk) begin
    int   nd;
    int   off;
    bit   stalled;
    exp_t e;
    if (reset || flush_i) begin
      mq.delete();
    end else begin
      stalled = (mq.size() > 12);
      nd = decodeReady_i ? ((mq.size() < 4) ? mq.size() : 4) : 0;
      for (int i = 0; i < nd; i++) void'(mq.pop_front());
      if (fs1Ready_i && !stalled) begin
        off = int'(pc_i[4:3]);
        for (int k = off; k < 4; k++) begin
          e.pc    = (pc_i & ~32'h1F) + 32'(k * 8);
          e.inst  = instructionBundle_i[k*64 +: 64];
          e.taken = btbHit_i[k] & prediction_i[k];
          e.tgt   = targetAddr_i[k*32 +: 32];
          mq.push_back(e);
          if (e.taken) break;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("stall", 64'(stall_o), 64'(mq.size() > 12));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("valid%0d", i), 64'(instValid_o[i]), 64'(i < mq.size()));
        if (i < mq.size()) begin
          check($sformatf("pc%0d", i), 64'(instPC_o[i*32 +: 32]), 64'(mq[i].pc));
          check($sformatf("inst%0d", i), inst_o[i*64 +: 64], mq[i].inst);
          check($sformatf("taken%0d", i), 64'(predTaken_o[i]), 64'(mq[i].taken));
          if (mq[i].taken)
            check($sformatf("target%0d", i), 64'(predTarget_o[i*32 +: 32]), 64'(mq[i].tgt));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush_i = 1'b0; fs1Ready_i = 1'b0; decodeReady_i = 1'b0;
    pc_i = '0; btbHit_i = '0; prediction_i = '0;
    instructionBundle_i = '0; targetAddr_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(instValid_o), 64'h0);
    check("rst_stall", 64'(stall_o), 64'h0);

    present(32'h1010, 4'b0000, 4'b0000);
    @(negedge clk); fs1Ready_i = 1'b0;
    check("off_valid", 64'(instValid_o), 64'b0011);
    check("off_pc0", 64'(instPC_o[31:0]), 64'h1010);
    check("off_pc1", 64'(instPC_o[63:32]), 64'h1018);
    decodeReady_i = 1'b1;
    @(negedge clk);
    check("drain_valid", 64'(instValid_o), 64'h0);

    // Empty buffer with decode ready: the new bundle only shows up next cycle.
    present(32'h3000, 4'b0000, 4'b0000);
    @(negedge clk); fs1Ready_i = 1'b0; decodeReady_i = 1'b0;
    check("empty_rd_valid", 64'(instValid_o), 64'b1111);
    check("empty_rd_pc0", 64'(instPC_o[31:0]), 64'h3000);
    decodeReady_i = 1'b1;
    @(negedge clk); decodeReady_i = 1'b0;

    present(32'h2000, 4'b0110, 4'b0100);
    @(negedge clk); fs1Ready_i = 1'b0;
    check("tkn_valid", 64'(instValid_o), 64'b0111);
    check("tkn_taken", 64'(predTaken_o & instValid_o), 64'b0100);
    check("tkn_pc2", 64'(instPC_o[95:64]), 64'h2010);
    check("tkn_tgt", 64'(predTarget_o[95:64]), 64'h2300);
    decodeReady_i = 1'b1;
    @(negedge clk); decodeReady_i = 1'b0;

    present(32'h6018, 4'b0000, 4'b0000);
    @(negedge clk); fs1Ready_i = 1'b0;
    check("one_valid", 64'(instValid_o), 64'b0001);
    decodeReady_i = 1'b1;
    @(negedge clk); decodeReady_i = 1'b0;

    for (int b = 0; b < 4; b++) begin
      present(32'h4000 + 32'(b * 32), 4'b0000, 4'b0000);
      @(negedge clk);
      check($sformatf("fill_stall%0d", b), 64'(stall_o), 64'(b == 3));
    end
    present(32'h4080, 4'b0000, 4'b0000);
    repeat (2) begin
      @(negedge clk);
      check("full_stall", 64'(stall_o), 64'h1);
      check("full_pc0", 64'(instPC_o[31:0]), 64'h4000);
    end
    fs1Ready_i = 1'b0; decodeReady_i = 1'b1;
    @(negedge clk); decodeReady_i = 1'b0;
    check("deq_stall", 64'(stall_o), 64'h0);
    check("deq_pc0", 64'(instPC_o[31:0]), 64'h4020);

    present(32'h5018, 4'b0000, 4'b0000);
    @(negedge clk); fs1Ready_i = 1'b0;
    check("c13_stall", 64'(stall_o), 64'h1);

    // Count 13, head 14: the 3-slot bundle waits while decode wraps head to 2.
    present(32'h7008, 4'b0000, 4'b0000);
    decodeReady_i = 1'b1;
    @(negedge clk); decodeReady_i = 1'b0;
    check("wrap_stall", 64'(stall_o), 64'h0);
    check("wrap_valid", 64'(instValid_o), 64'b1111);
    check("wrap_pc0", 64'(instPC_o[31:0]), 64'h4040);
    check("wrap_pc3", 64'(instPC_o[127:96]), 64'h4058);
    @(negedge clk); fs1Ready_i = 1'b0;
    check("held_stall", 64'(stall_o), 64'h0);

    present(32'h8010, 4'b0000, 4'b0000);
    decodeReady_i = 1'b1;
    @(negedge clk); fs1Ready_i = 1'b0; decodeReady_i = 1'b0;
    check("ten_pc0", 64'(instPC_o[31:0]), 64'h4060);

    flush_i = 1'b1;
    present(32'h9000, 4'b0000, 4'b0000);
    decodeReady_i = 1'b1;
    @(negedge clk); flush_i = 1'b0; fs1Ready_i = 1'b0; decodeReady_i = 1'b0;
    check("flush_valid", 64'(instValid_o), 64'h0);
    check("flush_stall", 64'(stall_o), 64'h0);
    @(negedge clk);
    check("flush_noenq", 64'(instValid_o), 64'h0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
